// File: rtl/uart_hex_console_pkg.sv
// uart_hex_console_pkg: receiver state encoding and hex-to-seven-segment table.
package uart_hex_console_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;
  localparam logic [15:0][7:0] SEG_LUT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
  function automatic logic [7:0] hex_seg(input logic [3:0] nib);
    return SEG_LUT[nib];
  endfunction
endpackage

// File: rtl/uart_hex_console_if.sv
// uart_hex_console_if: received-byte stream from the UART core to its consumer.
interface uart_hex_console_if;
  logic [7:0] data;
  logic       valid;
  modport master(output data, valid);
  modport slave(input data, valid);
endinterface

// File: rtl/uart_hex_console_rx_core.sv
// uart_rx_core: rxd synchronizer, fractional sample-tick generator and 8N1 receive FSM.
module uart_rx_core
  import uart_hex_console_pkg::*;
#(
  parameter int DIV_X      = 18,
  parameter int DIV_Y      = 1250,
  parameter int OVERSAMPLE = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rxd,
  uart_hex_console_if.master         rx
);
  localparam int AW = $clog2(DIV_X + DIV_Y);
  localparam int CW = $clog2(OVERSAMPLE + 1);
  logic [1:0]    sync_q;
  logic [AW-1:0] acc_q, acc_d, sum;
  logic          tick_q, tick_d, err_q, err_d, valid_q, valid_d, rx_s, mid, full;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bits_q, bits_d;
  logic [7:0]    shift_q, shift_d, data_q, data_d;
  assign rx_s = sync_q[1];
  assign rx.data = data_q;
  assign rx.valid = valid_q;
  always_comb begin
    sum = acc_q + AW'(DIV_X);
    tick_d = sum >= AW'(DIV_Y);
    acc_d = tick_d ? sum - AW'(DIV_Y) : sum;
    mid = cnt_q == CW'(OVERSAMPLE / 2 - 1);
    full = cnt_q == CW'(OVERSAMPLE - 1);
    state_d = state_q;
    cnt_d = cnt_q;
    bits_d = bits_q;
    shift_d = shift_q;
    data_d = data_q;
    valid_d = 1'b0;
    // a framing error keeps start detection off until the line goes idle again
    err_d = rx_s ? 1'b0 : err_q;
    if (tick_q) begin
      case (state_q)
        IDLE: begin
          state_d = (!rx_s && !err_q) ? START : IDLE;
          cnt_d = '0;
        end
        START: begin
          cnt_d = mid ? '0 : cnt_q + CW'(1);
          bits_d = '0;
          state_d = mid ? (rx_s ? IDLE : DATA) : START;
        end
        DATA: begin
          cnt_d = full ? '0 : cnt_q + CW'(1);
          shift_d = full ? {rx_s, shift_q[7:1]} : shift_q;
          bits_d = full ? bits_q + 3'd1 : bits_q;
          state_d = (full && bits_q == 3'd7) ? STOP : DATA;
        end
        STOP: begin
          cnt_d = full ? '0 : cnt_q + CW'(1);
          state_d = full ? IDLE : STOP;
          data_d = (full && rx_s) ? shift_q : data_q;
          valid_d = full && rx_s;
          err_d = full ? !rx_s : err_q;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      acc_q <= '0;
      tick_q <= 1'b0;
      state_q <= IDLE;
      cnt_q <= '0;
      bits_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rxd};
      acc_q <= acc_d;
      tick_q <= tick_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      bits_q <= bits_d;
      shift_q <= shift_d;
      data_q <= data_d;
      valid_q <= valid_d;
      err_q <= err_d;
    end
  end
endmodule

// File: rtl/uart_hex_console.sv
// uart_hex_console: UART byte receiver driving a 4-digit multiplexed hex display.
module uart_hex_console
  import uart_hex_console_pkg::*;
#(
  parameter int          DIV_X       = 18,
  parameter int          DIV_Y       = 1250,
  parameter int          OVERSAMPLE  = 16,
  parameter int          REFRESH_DIV = 65536,
  parameter logic [15:0] INIT_DATA   = 16'hAA00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic [3:0] anodes,
  output logic [7:0] seg
);
  localparam int RW = $clog2(REFRESH_DIV + 1);
  uart_hex_console_if rx_if ();
  uart_rx_core #(.DIV_X(DIV_X), .DIV_Y(DIV_Y), .OVERSAMPLE(OVERSAMPLE)) u_rx (
    .clk  (clk),
    .rst_n(rst_n),
    .rxd  (rxd),
    .rx   (rx_if)
  );
  assign rx_data = rx_if.data;
  assign rx_valid = rx_if.valid;
  logic [RW-1:0] ref_q, ref_d;
  logic [1:0]    dig_q, dig_d;
  logic [15:0]   disp_q, disp_d;
  logic [3:0]    anodes_q, anodes_d;
  logic [7:0]    seg_q, seg_d;
  logic          wrap;
  always_comb begin
    wrap = ref_q == RW'(REFRESH_DIV - 1);
    ref_d = wrap ? '0 : ref_q + RW'(1);
    dig_d = wrap ? dig_q + 2'd1 : dig_q;
    disp_d = rx_if.valid ? {disp_q[15:8], rx_if.data} : disp_q;
    anodes_d = ~(4'b0001 << dig_d);
    seg_d = hex_seg(disp_q[{dig_d, 2'b00} +: 4]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q <= '0;
      dig_q <= '0;
      disp_q <= INIT_DATA;
      anodes_q <= 4'b1110;
      seg_q <= hex_seg(INIT_DATA[3:0]);
    end else begin
      ref_q <= ref_d;
      dig_q <= dig_d;
      disp_q <= disp_d;
      anodes_q <= anodes_d;
      seg_q <= seg_d;
    end
  end
  assign anodes = anodes_q;
  assign seg = seg_q;
endmodule

// File: tb/tb_uart_hex_console.sv
// tb_uart_hex_console: directed UART frames with a queue scoreboard on the received-byte stream.
module tb_uart_hex_console;
  import uart_hex_console_pkg::*;
  localparam int BIT = 1111;
  localparam int REF = 16;
  logic clk = 0, rst_n = 0, rxd = 1;
  logic [7:0] rx_data, seg;
  logic rx_valid;
  logic [3:0] anodes;
  int vectors = 0, errors = 0;
  logic [7:0] exp_q[$];
  logic prev_v = 0;
  uart_hex_console_if bus ();
  assign bus.data = rx_data;
  assign bus.valid = rx_valid;
  uart_hex_console #(.REFRESH_DIV(REF)) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .rx_data(rx_data),
    .rx_valid(rx_valid), .anodes(anodes), .seg(seg)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] seg_model(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
      4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
      4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
      4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
    endcase
  endfunction
  always @(negedge clk) begin
    if (rst_n && bus.valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_valid: got data %h with no byte expected", bus.data);
      end else chk("rx_data", bus.data, exp_q.pop_front());
      if (prev_v) begin
        vectors++;
        errors++;
        $display("FAIL valid_width: got pulse longer than 1 clk expected 1");
      end
    end
    prev_v = bus.valid;
  end
  task automatic check_display(input logic [15:0] d);
    for (int k = 0; k < 4; k++) begin
      logic [3:0] an_exp = ~(4'b0001 << k);
      logic [3:0] nib = d[k*4 +: 4];
      int n = 0;
      while (anodes !== an_exp && n < 8 * REF) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("anodes%0d", k), anodes, an_exp);
      chk($sformatf("seg%0d", k), seg, seg_model(nib));
    end
  endtask
  task automatic send(input logic [7:0] b, input logic stop);
    rxd = 0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT) @(posedge clk);
    end
    rxd = stop;
    repeat (BIT) @(posedge clk);
  endtask
  initial begin
    int cnt, wide;
    logic prev_t;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_anodes", anodes, 4'b1110);
    chk("rst_seg", seg, 8'hC0);
    @(posedge clk);
    rst_n = 1;
    check_display(16'hAA00);
    cnt = 0;
    wide = 0;
    prev_t = 0;
    repeat (1250) begin
      @(negedge clk);
      if (dut.u_rx.tick_q) cnt++;
      if (dut.u_rx.tick_q && prev_t) wide++;
      prev_t = dut.u_rx.tick_q;
    end
    chk("tick_count", cnt, 18);
    chk("tick_wide", wide, 0);
    @(posedge clk);
    exp_q.push_back(8'h55);
    send(8'h55, 1);
    repeat (BIT) @(posedge clk);
    chk("pending_55", exp_q.size(), 0);
    check_display(16'hAA55);
    @(posedge clk);
    exp_q.push_back(8'hA7);
    exp_q.push_back(8'h3C);
    send(8'hA7, 1);
    send(8'h3C, 1);
    repeat (BIT) @(posedge clk);
    chk("pending_b2b", exp_q.size(), 0);
    check_display(16'hAA3C);
    @(posedge clk);
    send(8'h12, 0);
    repeat (2 * BIT) @(posedge clk);
    rxd = 1;
    repeat (2 * BIT) @(posedge clk);
    chk("framing_hold", rx_data, 8'h3C);
    check_display(16'hAA3C);
    @(posedge clk);
    rxd = 0;
    repeat (4 * 1250 / 18) @(posedge clk);
    rxd = 1;
    repeat (BIT) @(posedge clk);
    chk("glitch_idle", 32'(dut.u_rx.state_q), 32'(IDLE));
    chk("glitch_data", rx_data, 8'h3C);
    rxd = 0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      rxd = i[0];
      repeat (BIT) @(posedge clk);
    end
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("midrst_rx_data", rx_data, 8'h00);
    chk("midrst_rx_valid", rx_valid, 1'b0);
    chk("midrst_anodes", anodes, 4'b1110);
    chk("midrst_seg", seg, 8'hC0);
    rxd = 1;
    repeat (3) @(posedge clk);
    rst_n = 1;
    repeat (2 * BIT) @(posedge clk);
    chk("post_rst_data", rx_data, 8'h00);
    check_display(16'hAA00);
    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/uart_hex_console.md
UART_HEX_CONSOLE -- requirements
Module: uart_hex_console

Interface
REQ-001 SHALL have parameter DIV_X, default 18, fractional-divider increment.
REQ-002 SHALL have parameter DIV_Y, default 1250, fractional-divider modulus; DIV_X < DIV_Y.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, sample ticks per UART bit.
REQ-004 SHALL have parameter REFRESH_DIV, default 65536, clk cycles per display digit slot.
REQ-005 SHALL have parameter INIT_DATA, default 16'hAA00, display register reset value.
REQ-006 SHALL use one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-008 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-009 SHALL have port rxd  input  1  asynchronous UART serial line, idle high.
REQ-010 SHALL have port rx_data  output  8  last correctly received byte.
REQ-011 SHALL have port rx_valid  output  1  one-clk pulse when rx_data updates.
REQ-012 SHALL have port anodes  output  4  digit enables, active-low.
REQ-013 SHALL have port seg  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.

Function
REQ-014 SHALL generate the sample tick as a clock enable, not a derived clock: accumulator += DIV_X each clk; when sum >= DIV_Y, subtract DIV_Y and assert tick for exactly one clk.
REQ-015 SHALL synchronize rxd through two flops before any use.
REQ-016 SHALL receive 8N1 frames, LSB first, with FSM IDLE, START, DATA, STOP; all state advances occur only on tick.
REQ-017 IDLE: on synchronized rxd low, go to START with tick counter cleared.
REQ-018 START: at OVERSAMPLE/2 ticks resample; low -> DATA, high -> IDLE (glitch rejected).
REQ-019 DATA: sample one bit every OVERSAMPLE ticks (mid-bit), shift in LSB first; after bit 7 go to STOP.
REQ-020 STOP: after OVERSAMPLE ticks sample; high -> load rx_data, pulse rx_valid, go IDLE; low -> framing error, discard byte, stay in IDLE until rxd returns high.
REQ-021 SHALL hold display register disp[15:0]; on rx_valid disp[7:0] <= rx_data, disp[15:8] unchanged.
REQ-022 SHALL scan digits round-robin every REFRESH_DIV clk: digit 0 (anodes=4'b1110) shows disp[3:0] ... digit 3 (anodes=4'b0111) shows disp[15:12]; exactly one anode low at all times after reset.
REQ-023 SHALL decode hex to seg (dp=1, off): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
REQ-024 anodes and seg SHALL change on the same clk edge (registered together).

Reset
REQ-025 rst_n low SHALL immediately force: accumulator 0, tick 0, FSM IDLE, shift register 0, rx_data 8'h00, rx_valid 0, disp INIT_DATA, scan counter 0, anodes 4'b1110, seg decode of digit 0 of INIT_DATA.
REQ-026 Reset mid-frame SHALL abandon the frame; no rx_valid pulse for it.
REQ-027 Synchronizer flops SHALL reset to 1 (idle).

Structure
REQ-028 Shared package SHALL hold the FSM state enum and the 16-entry segment table.
REQ-029 One sub-module, uart_rx_core (synchronizer, tick generator, FSM), is natural; divider and display stay in the top.

Verification
REQ-030 Reset release -> disp=16'hAA00, anodes cycle 1110,1101,1011,0111, seg C0,C0,88,88.
REQ-031 Send 0x55 (8N1, exact baud) -> one rx_valid pulse, rx_data=8'h55, disp=16'hAA55, digit 0 seg=92.
REQ-032 Send 0xA7 then 0x3C back-to-back -> two pulses, final disp=16'hAA3C.
REQ-033 Frame 0x12 with stop bit low -> no rx_valid, rx_data and disp unchanged.
REQ-034 Low glitch of OVERSAMPLE/4 ticks on idle line -> FSM returns IDLE, no rx_valid.
REQ-035 Count ticks over 1250 clk with defaults -> exactly 18 ticks, each one clk wide; rst_n low mid-frame -> outputs at reset values immediately.
